// File: rtl/module_keypad_scan.sv
// 4x4 keypad scanner: column rotation, press qualification, valid/ready key output.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_CYC cycles.
module module_keypad_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int STABLE_CYC = 8,
  parameter int REPEAT_CYC = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready
);

  if (SCAN_DIV < 2 || STABLE_CYC < 1 || REPEAT_CYC < 1) begin : g_param_chk
    $error("module_keypad_scan: parameter out of range");
  end

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(STABLE_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYC - 1);

  typedef enum logic [1:0] {
    SCAN,
    DETECT,
    HOLD_OUT,
    WAIT_RELEASE
  } state_t;

  state_t           state, state_n;
  logic [1:0]       col_idx, col_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [STB_W-1:0] stab_cnt, stab_n;
  logic [3:0]       ref_row, ref_n;
  logic [3:0]       code_q, code_n;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_cnt, rep_n;
`endif

  // Row 0 wins when several rows are active in the same column.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_comb begin
    state_n = state;
    col_n   = col_idx;
    div_n   = div_cnt;
    stab_n  = stab_cnt;
    ref_n   = ref_row;
    code_n  = code_q;
`ifdef KEYPAD_REPEAT_EN
    rep_n   = rep_cnt;
`endif
    unique case (state)
      SCAN: begin
        if (row_in != 4'd0) begin
          state_n = DETECT;
          ref_n   = row_in;
          stab_n  = '0;
          div_n   = '0;
        end else if (div_cnt == DIV_LAST) begin
          div_n = '0;
          col_n = col_idx + 2'd1;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      DETECT: begin
        if (row_in == 4'd0) begin
          state_n = SCAN;
          stab_n  = '0;
        end else if (row_in != ref_row) begin
          ref_n  = row_in;
          stab_n = '0;
        end else if (stab_cnt == STB_LAST) begin
          state_n = HOLD_OUT;
          code_n  = {low_row(ref_row), col_idx};
          stab_n  = '0;
        end else begin
          stab_n = stab_cnt + 1'b1;
        end
      end
      HOLD_OUT: begin
        if (key_ready) begin
          state_n = WAIT_RELEASE;
          stab_n  = '0;
`ifdef KEYPAD_REPEAT_EN
          rep_n   = '0;
`endif
        end
      end
      WAIT_RELEASE: begin
        if (row_in == 4'd0) begin
          if (stab_cnt == STB_LAST) begin
            state_n = SCAN;
            stab_n  = '0;
          end else begin
            stab_n = stab_cnt + 1'b1;
          end
        end else begin
          stab_n = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        // Only an unchanged hold of the same pattern counts toward repeat.
        if (row_in == ref_row) begin
          if (rep_cnt == REP_LAST) begin
            state_n = HOLD_OUT;
            rep_n   = '0;
          end else begin
            rep_n = rep_cnt + 1'b1;
          end
        end else begin
          rep_n = '0;
        end
`endif
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCAN;
      col_idx  <= 2'd0;
      div_cnt  <= '0;
      stab_cnt <= '0;
      ref_row  <= 4'd0;
      code_q   <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      col_idx  <= col_n;
      div_cnt  <= div_n;
      stab_cnt <= stab_n;
      ref_row  <= ref_n;
      code_q   <= code_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= rep_n;
`endif
    end
  end

  assign col_out   = 4'b0001 << col_idx;
  assign key_code  = code_q;
  assign key_valid = (state == HOLD_OUT);

endmodule

// File: doc/module_keypad_scan.md
MODULE_KEYPAD_SCAN -- requirements
Module: module_keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven before rotating (minimum 2).
REQ-002 SHALL have parameter STABLE_CYC, default 8: consecutive cycles a row pattern must hold before a key is accepted (minimum 1).
REQ-003 SHALL have parameter REPEAT_CYC, default 25000000: hold time in cycles before auto-repeat; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port row_in, input, 4 bits: debounced keypad rows, active-high.
REQ-007 SHALL have port col_out, output, 4 bits: one-hot active-high column drive.
REQ-008 SHALL have port key_code, output, 4 bits: accepted key, equal to row_index*4 + col_index.
REQ-009 SHALL have port key_valid, output, 1 bit: key_code is valid; held until accepted.
REQ-010 SHALL have port key_ready, input, 1 bit: consumer accepts key_code when key_valid and key_ready are both 1 on a rising edge.

Function
REQ-011 SHALL implement the FSM states SCAN, DETECT, HOLD_OUT and WAIT_RELEASE.
REQ-012 SCAN SHALL drive col_out 0001, 0010, 0100, 1000, then wrap to 0001, advancing after every SCAN_DIV cycles; the divider counter SHALL wrap to 0.
REQ-013 SCAN SHALL go to DETECT on the first cycle row_in != 0, freezing col_out and capturing row_in as the reference pattern.
REQ-014 DETECT SHALL count cycles while row_in equals the reference; if row_in changes to another nonzero value, it SHALL reload the reference and restart the count.
REQ-015 DETECT SHALL return to SCAN with no output if row_in becomes 0 before the count reaches STABLE_CYC; column rotation then resumes from the frozen column.
REQ-016 On reaching STABLE_CYC, DETECT SHALL latch key_code from the lowest set bit of the reference (row priority 0 > 3) plus the frozen column index, and enter HOLD_OUT with key_valid=1 on the next cycle.
REQ-017 HOLD_OUT SHALL keep key_valid and key_code constant until handshake; on handshake, key_valid SHALL be 0 the next cycle and the FSM SHALL enter WAIT_RELEASE.
REQ-018 WAIT_RELEASE SHALL keep col_out frozen and return to SCAN only after row_in==0 for STABLE_CYC consecutive cycles; any nonzero row_in SHALL restart that count.
REQ-019 A press released while in HOLD_OUT SHALL NOT cancel key_valid; exactly one key_code SHALL be produced per press (absent repeat).
REQ-020 Latency from row_in first nonzero to key_valid=1 SHALL be STABLE_CYC+1 cycles for a stable press.

Reset
REQ-021 While rst=1 on a rising edge, the block SHALL enter SCAN with col_out=0001, key_code=0, key_valid=0, and all counters at 0.
REQ-022 Reset asserted in any state, including HOLD_OUT with a pending key, SHALL discard the key without a handshake.
REQ-023 The first column rotation after reset release SHALL occur SCAN_DIV cycles later.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN: when defined, after a handshake the WAIT_RELEASE state SHALL count continuous-hold cycles while row_in equals the reference. On reaching REPEAT_CYC it SHALL re-present the same key_code with key_valid=1 (entering HOLD_OUT) and restart the count after each handshake.
REQ-025 When KEYPAD_REPEAT_EN is undefined, the repeat counter logic SHALL be absent and held keys SHALL never re-emit.

Verification (SCAN_DIV=4, STABLE_CYC=3, REPEAT_CYC=20)
REQ-026 Idle, row_in=0 after reset -> col_out rotates 0001,0010,0100,1000,0001 every 4 cycles; key_valid stays 0.
REQ-027 row_in=0100 while col_out=0010, held stable, key_ready=1 -> key_valid=1 for exactly one cycle, 4 cycles after press, with key_code=9; no second key until after release plus 3 clear cycles.
REQ-028 row_in=0001 for 2 cycles then 0 -> no key_valid; scan resumes from the frozen column.
REQ-029 row_in=1010 at col_out=1000 with key_ready=0 for 10 cycles, then 1 -> key_code=7, key_valid held 10 cycles, cleared the cycle after the handshake.
REQ-030 rst=1 during HOLD_OUT -> next cycle key_valid=0, key_code=0, col_out=0001.
REQ-031 With KEYPAD_REPEAT_EN defined, key 5 held 50 cycles with key_ready=1 -> one initial key_valid pulse plus repeats every 21 cycles, each with key_code=5; without the macro -> exactly one pulse.
